// File: rtl/mips_cpu_data_mem_if_if.sv
// CPU-side request/response and Avalon-MM style bus signals of the data memory interface.
// slave = the memory interface block, master = its environment (CPU datapath plus bus slave).
interface mips_cpu_data_mem_if_if;
  logic        clk_enable;
  logic        data_read;
  logic        data_write;
  logic [3:0]  byte_enable;
  logic        load_signed;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        stall;
  logic        done;
  logic [31:0] rdata;
  logic        err;
  logic [31:0] mem_address;
  logic        mem_read;
  logic        mem_write;
  logic [3:0]  mem_byteenable;
  logic [31:0] mem_writedata;
  logic [31:0] mem_readdata;
  logic        mem_waitrequest;

  modport slave (
    input  clk_enable, data_read, data_write, byte_enable, load_signed, addr, wdata,
    output stall, done, rdata, err,
    output mem_address, mem_read, mem_write, mem_byteenable, mem_writedata,
    input  mem_readdata, mem_waitrequest
  );

  modport master (
    output clk_enable, data_read, data_write, byte_enable, load_signed, addr, wdata,
    input  stall, done, rdata, err,
    input  mem_address, mem_read, mem_write, mem_byteenable, mem_writedata,
    output mem_readdata, mem_waitrequest
  );
endinterface

// File: rtl/mips_cpu_data_mem_if.sv
// Turns one CPU load/store into a single word-aligned bus transaction, stalling the CPU
// until the bus completes, and returns lane-aligned, extended load data.
module mips_cpu_data_mem_if (
  input logic                   clk,
  input logic                   reset,
  mips_cpu_data_mem_if_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RD_WAIT, WR_WAIT, RESP} state_t;
  typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD} size_t;

  state_t      state_q, state_d;
  size_t       size_q, size_d;
  logic [1:0]  off_q, off_d;
  logic        sign_q, sign_d;
  logic        load_q, load_d;
  logic        err_q, err_d;
  logic [31:0] rcap_q, rcap_d;
  logic [31:0] mem_address_q, mem_address_d;
  logic [31:0] mem_writedata_q, mem_writedata_d;
  logic [3:0]  mem_byteenable_q, mem_byteenable_d;
  logic        mem_read_q, mem_read_d;
  logic        mem_write_q, mem_write_d;

  logic        accept;
  logic        illegal;
  size_t       req_size;
  logic [31:0] shifted;
  logic [31:0] fmt;

  assign accept = (state_q == IDLE) & bus.clk_enable & (bus.data_read | bus.data_write);

  always_comb begin
    req_size = SZ_WORD;
    illegal  = bus.data_read & bus.data_write;
    case (bus.byte_enable)
      4'b0001: req_size = SZ_BYTE;
      4'b0011: begin
        req_size = SZ_HALF;
        if (bus.addr[0]) illegal = 1'b1;
      end
      4'b1111: begin
        req_size = SZ_WORD;
        if (bus.addr[1:0] != 2'b00) illegal = 1'b1;
      end
      default: illegal = 1'b1;
    endcase
  end

  always_comb begin
    state_d          = state_q;
    size_d           = size_q;
    off_d            = off_q;
    sign_d           = sign_q;
    load_d           = load_q;
    err_d            = err_q;
    rcap_d           = rcap_q;
    mem_address_d    = mem_address_q;
    mem_writedata_d  = mem_writedata_q;
    mem_byteenable_d = mem_byteenable_q;
    mem_read_d       = mem_read_q;
    mem_write_d      = mem_write_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          size_d = req_size;
          off_d  = bus.addr[1:0];
          sign_d = bus.load_signed;
          load_d = bus.data_read;
          err_d  = illegal;
          if (illegal) begin
            state_d = RESP;
          end else begin
            mem_address_d    = {bus.addr[31:2], 2'b00};
            mem_byteenable_d = bus.byte_enable << bus.addr[1:0];
            if (bus.data_read) begin
              mem_read_d = 1'b1;
              state_d    = RD_WAIT;
            end else begin
              mem_write_d     = 1'b1;
              mem_writedata_d = bus.wdata << {bus.addr[1:0], 3'b000};
              state_d         = WR_WAIT;
            end
          end
        end
      end
      RD_WAIT, WR_WAIT: begin
        if (!bus.mem_waitrequest) begin
          if (state_q == RD_WAIT) rcap_d = bus.mem_readdata;
          // Bus outputs return to inactive as soon as the slave completes.
          mem_address_d    = 32'h0;
          mem_writedata_d  = 32'h0;
          mem_byteenable_d = 4'h0;
          mem_read_d       = 1'b0;
          mem_write_d      = 1'b0;
          state_d          = RESP;
        end
      end
      default: begin
        err_d   = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q          <= IDLE;
      size_q           <= SZ_BYTE;
      off_q            <= 2'b00;
      sign_q           <= 1'b0;
      load_q           <= 1'b0;
      err_q            <= 1'b0;
      rcap_q           <= 32'h0;
      mem_address_q    <= 32'h0;
      mem_writedata_q  <= 32'h0;
      mem_byteenable_q <= 4'h0;
      mem_read_q       <= 1'b0;
      mem_write_q      <= 1'b0;
    end else begin
      state_q          <= state_d;
      size_q           <= size_d;
      off_q            <= off_d;
      sign_q           <= sign_d;
      load_q           <= load_d;
      err_q            <= err_d;
      rcap_q           <= rcap_d;
      mem_address_q    <= mem_address_d;
      mem_writedata_q  <= mem_writedata_d;
      mem_byteenable_q <= mem_byteenable_d;
      mem_read_q       <= mem_read_d;
      mem_write_q      <= mem_write_d;
    end
  end

  assign shifted = rcap_q >> {off_q, 3'b000};

  always_comb begin
    case (size_q)
      SZ_BYTE: fmt = {{24{sign_q & shifted[7]}}, shifted[7:0]};
      SZ_HALF: fmt = {{16{sign_q & shifted[15]}}, shifted[15:0]};
      default: fmt = shifted;
    endcase
  end

  // Stall is combinational so the CPU freezes in the very cycle it issues the request.
  assign bus.stall          = ~reset & ((state_q == RD_WAIT) | (state_q == WR_WAIT) | accept);
  assign bus.done           = (state_q == RESP);
  assign bus.err            = (state_q == RESP) & err_q;
  assign bus.rdata          = ((state_q == RESP) & load_q & ~err_q) ? fmt : 32'h0;
  assign bus.mem_address    = mem_address_q;
  assign bus.mem_read       = mem_read_q;
  assign bus.mem_write      = mem_write_q;
  assign bus.mem_byteenable = mem_byteenable_q;
  assign bus.mem_writedata  = mem_writedata_q;
endmodule

// File: tb/tb_mips_cpu_data_mem_if.sv
// Scoreboard bench: stimulus pushes expected bus requests and CPU responses; a bus-slave
// monitor and a response monitor pop and compare them as the DUT presents them.
module tb_mips_cpu_data_mem_if;
  logic clk;
  logic reset;
  mips_cpu_data_mem_if_if bus ();

  mips_cpu_data_mem_if dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        err;
    logic        is_load;
    logic [31:0] rdata;
    string       nm;
  } resp_t;

  typedef struct {
    logic [31:0] maddr;
    logic [3:0]  be;
    logic        wr;
    logic [31:0] wdata;
    string       nm;
  } busreq_t;

  resp_t   resp_q[$];
  busreq_t bus_q[$];

  int          checks = 0;
  int          errors = 0;
  int          slave_waits = 0;
  logic [31:0] slave_rdata = 32'h0;
  int          strobe_cycles = 0;
  int          wait_left = 0;
  logic        in_xfer = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  // Bus slave model plus request monitor: checks each new transfer on its first strobe cycle.
  always @(negedge clk) begin
    if (bus.mem_read || bus.mem_write) begin
      strobe_cycles++;
      if (!in_xfer) begin
        in_xfer   = 1'b1;
        wait_left = slave_waits;
        if (bus_q.size() == 0) begin
          chk("unexpected_bus_cycle", 32'd1, 32'd0);
        end else begin
          busreq_t e;
          e = bus_q.pop_front();
          chk({e.nm, "_mem_address"}, bus.mem_address, e.maddr);
          chk({e.nm, "_mem_byteenable"}, {28'h0, bus.mem_byteenable}, {28'h0, e.be});
          chk({e.nm, "_mem_write"}, {31'h0, bus.mem_write}, {31'h0, e.wr});
          chk({e.nm, "_mem_read"}, {31'h0, bus.mem_read}, {31'h0, ~e.wr});
          if (e.wr) chk({e.nm, "_mem_writedata"}, bus.mem_writedata, e.wdata);
        end
      end
      bus.mem_waitrequest = (wait_left > 0);
      if (wait_left > 0) wait_left--;
      bus.mem_readdata = slave_rdata;
    end else begin
      in_xfer             = 1'b0;
      bus.mem_waitrequest = 1'b0;
      bus.mem_readdata    = 32'h0;
    end
  end

  // Response monitor.
  always @(negedge clk) begin
    if (bus.done === 1'b1) begin
      if (resp_q.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        resp_t r;
        r = resp_q.pop_front();
        chk({r.nm, "_err"}, {31'h0, bus.err}, {31'h0, r.err});
        if (r.is_load) chk({r.nm, "_rdata"}, bus.rdata, r.rdata);
      end
    end
  end

  task automatic req(input string nm, input logic rd, input logic wr, input logic [3:0] be,
                     input logic sg, input logic [31:0] a, input logic [31:0] wd,
                     input int waits, input logic [31:0] mrd, input int exp_done,
                     input logic exp_err, input logic [31:0] exp_rdata,
                     input logic [31:0] exp_maddr, input logic [3:0] exp_be,
                     input logic [31:0] exp_wdata);
    resp_t   r;
    busreq_t b;
    int      cyc;
    int      stall_cnt;
    int      strobe_start;
    r.err = exp_err; r.is_load = rd & ~exp_err; r.rdata = exp_rdata; r.nm = nm;
    resp_q.push_back(r);
    if (!exp_err) begin
      b.maddr = exp_maddr; b.be = exp_be; b.wr = wr; b.wdata = exp_wdata; b.nm = nm;
      bus_q.push_back(b);
    end
    slave_waits  = waits;
    slave_rdata  = mrd;
    strobe_start = strobe_cycles;
    stall_cnt    = 0;
    @(posedge clk); #1;
    bus.clk_enable  = 1'b1;
    bus.data_read   = rd;
    bus.data_write  = wr;
    bus.byte_enable = be;
    bus.load_signed = sg;
    bus.addr        = a;
    bus.wdata       = wd;
    for (cyc = 0; cyc < 40; cyc++) begin
      @(negedge clk);
      if (cyc == 0) chk({nm, "_stall_accept"}, {31'h0, bus.stall}, 32'd1);
      else if (bus.stall) stall_cnt++;
      if (bus.done) break;
      @(posedge clk); #1;
    end
    chk({nm, "_done_cycle"}, cyc, exp_done);
    chk({nm, "_stall_cycles"}, stall_cnt, exp_done - 1);
    chk({nm, "_strobe_cycles"}, strobe_cycles - strobe_start, exp_err ? 0 : waits + 1);
    chk({nm, "_bus_idle_resp"}, {30'h0, bus.mem_read, bus.mem_write}, 32'd0);
    @(posedge clk); #1;
    bus.data_read  = 1'b0;
    bus.data_write = 1'b0;
    @(negedge clk);
    chk({nm, "_done_pulse"}, {31'h0, bus.done}, 32'd0);
  endtask

  initial begin
    reset           = 1'b1;
    bus.clk_enable  = 1'b0;
    bus.data_read   = 1'b0;
    bus.data_write  = 1'b0;
    bus.byte_enable = 4'h0;
    bus.load_signed = 1'b0;
    bus.addr        = 32'h0;
    bus.wdata       = 32'h0;
    #2;
    chk("rst_stall", {31'h0, bus.stall}, 32'd0);
    chk("rst_done_err", {30'h0, bus.done, bus.err}, 32'd0);
    chk("rst_strobes", {30'h0, bus.mem_read, bus.mem_write}, 32'd0);
    chk("rst_byteenable", {28'h0, bus.mem_byteenable}, 32'd0);
    chk("rst_rdata", bus.rdata, 32'd0);
    chk("rst_mem_address", bus.mem_address, 32'd0);
    chk("rst_mem_writedata", bus.mem_writedata, 32'd0);
    repeat (2) @(negedge clk);
    #1 reset = 1'b0;

    //   name        rd    wr    be       sg    addr          wdata         w  mem_readdata  done err   rdata         maddr         be       wdata
    req("lw_100",    1'b1, 1'b0, 4'b1111, 1'b0, 32'h0000_0100, 32'h0,        0, 32'hDEADBEEF, 2, 1'b0, 32'hDEADBEEF, 32'h0000_0100, 4'b1111, 32'h0);
    req("lb_s_103",  1'b1, 1'b0, 4'b0001, 1'b1, 32'h0000_0103, 32'h0,        0, 32'h80FF0000, 2, 1'b0, 32'hFFFFFF80, 32'h0000_0100, 4'b1000, 32'h0);
    req("lb_u_103",  1'b1, 1'b0, 4'b0001, 1'b0, 32'h0000_0103, 32'h0,        0, 32'h80FF0000, 2, 1'b0, 32'h00000080, 32'h0000_0100, 4'b1000, 32'h0);
    req("sh_202_w3", 1'b0, 1'b1, 4'b0011, 1'b0, 32'h0000_0202, 32'h1234ABCD, 3, 32'h0,        5, 1'b0, 32'h0,        32'h0000_0200, 4'b1100, 32'hABCD0000);
    req("lh_s_102",  1'b1, 1'b0, 4'b0011, 1'b1, 32'h0000_0102, 32'h0,        1, 32'h80011234, 3, 1'b0, 32'hFFFF8001, 32'h0000_0100, 4'b1100, 32'h0);
    req("lbu_101",   1'b1, 1'b0, 4'b0001, 1'b0, 32'h0000_0101, 32'h0,        0, 32'h0000A500, 2, 1'b0, 32'h000000A5, 32'h0000_0100, 4'b0010, 32'h0);
    req("sb_101",    1'b0, 1'b1, 4'b0001, 1'b0, 32'h0000_0101, 32'h12345678, 0, 32'h0,        2, 1'b0, 32'h0,        32'h0000_0100, 4'b0010, 32'h34567800);
    req("lh_201_ill",1'b1, 1'b0, 4'b0011, 1'b0, 32'h0000_0201, 32'h0,        0, 32'h0,        1, 1'b1, 32'h0,        32'h0,         4'b0000, 32'h0);
    req("sw_002_ill",1'b0, 1'b1, 4'b1111, 1'b0, 32'h0000_0002, 32'h55AA55AA, 0, 32'h0,        1, 1'b1, 32'h0,        32'h0,         4'b0000, 32'h0);
    req("rdwr_ill",  1'b1, 1'b1, 4'b1111, 1'b0, 32'h0000_0100, 32'h0,        0, 32'h0,        1, 1'b1, 32'h0,        32'h0,         4'b0000, 32'h0);
    req("be0111_ill",1'b1, 1'b0, 4'b0111, 1'b0, 32'h0000_0100, 32'h0,        0, 32'h0,        1, 1'b1, 32'h0,        32'h0,         4'b0000, 32'h0);

    // Reset while the slave holds waitrequest: transaction abandoned, no response expected.
    begin
      busreq_t b;
      b.maddr = 32'h0000_0300; b.be = 4'b1111; b.wr = 1'b0; b.wdata = 32'h0; b.nm = "lw_rst";
      bus_q.push_back(b);
    end
    slave_waits = 1000;
    @(posedge clk); #1;
    bus.clk_enable  = 1'b1;
    bus.data_read   = 1'b1;
    bus.byte_enable = 4'b1111;
    bus.addr        = 32'h0000_0300;
    repeat (3) @(negedge clk);
    chk("rst_mid_read_before", {31'h0, bus.mem_read}, 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("rst_mid_read", {31'h0, bus.mem_read}, 32'd0);
    chk("rst_mid_stall", {31'h0, bus.stall}, 32'd0);
    chk("rst_mid_done", {31'h0, bus.done}, 32'd0);
    bus.data_read = 1'b0;
    @(negedge clk); #1;
    reset       = 1'b0;
    slave_waits = 0;
    req("lw_after_rst", 1'b1, 1'b0, 4'b1111, 1'b0, 32'h0000_0104, 32'h0, 0, 32'h01234567, 2, 1'b0, 32'h01234567, 32'h0000_0104, 4'b1111, 32'h0);

    // clk_enable low: request present but not accepted.
    @(posedge clk); #1;
    bus.clk_enable  = 1'b0;
    bus.data_read   = 1'b1;
    bus.byte_enable = 4'b1111;
    bus.addr        = 32'h0000_0108;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("gate_stall", {31'h0, bus.stall}, 32'd0);
      chk("gate_bus_idle", {30'h0, bus.mem_read, bus.mem_write}, 32'd0);
    end
    req("lw_gated", 1'b1, 1'b0, 4'b1111, 1'b0, 32'h0000_0108, 32'h0, 0, 32'hCAFEF00D, 2, 1'b0, 32'hCAFEF00D, 32'h0000_0108, 4'b1111, 32'h0);

    repeat (3) @(negedge clk);
    chk("resp_queue_empty", resp_q.size(), 32'd0);
    chk("bus_queue_empty", bus_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
